// File: rtl/psk_pkg.sv
// Shared constants, state encoding and helpers for the PSK receive chain.
package psk_pkg;

  localparam logic [3:0]  MODE_BPSK         = 4'b0001;
  localparam logic [3:0]  MODE_QPSK         = 4'b0010;
  localparam logic [3:0]  MODE_MIX          = 4'b0100;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hEB90;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD
  } rx_state_e;

  function automatic logic mode_valid(input logic [3:0] mode);
    return (mode == MODE_BPSK) || (mode == MODE_QPSK) || (mode == MODE_MIX);
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/sync_correlator.sv
// 16-bit sync hunter: shifts in 1 or 2 bits per strobe and compares the
// updated window against the sync word and its complement within a tolerance.
module sync_correlator
  import psk_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int unsigned SYNC_TOL  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       shift,
  input  logic       two_bits,
  input  logic [1:0] bits,
  output logic       match,
  output logic       inv_match
);

  logic [15:0] sr_q, sr_d;
  logic [4:0]  err_true, err_inv;

  // Compare the window as it will look after this shift, so a hit is
  // reported on the same strobe that completes the sync word.
  always_comb begin
    sr_d     = two_bits ? {sr_q[13:0], bits[1], bits[0]} : {sr_q[14:0], bits[0]};
    err_true = popcount16(sr_d ^ SYNC_WORD);
    err_inv  = popcount16(sr_d ^ ~SYNC_WORD);
  end

  assign match     = shift && (err_true <= 5'(SYNC_TOL));
  assign inv_match = shift && (err_inv <= 5'(SYNC_TOL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (clear) begin
      sr_q <= '0;
    end else if (shift) begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/rx_deframer.sv
// Receive deframer: sync hunt (true or inverted), length byte, MSB-first
// payload packing onto an 8-bit AXI-Stream master.
module rx_deframer
  import psk_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter int unsigned SYNC_TOL  = 0
) (
  input  logic       clk_16M384,
  input  logic       rst_16M384,
  input  logic [3:0] MODE_CTRL,
  input  logic [1:0] RX_bits,
  input  logic       RX_vld,
  output logic [7:0] data_tdata,
  output logic       data_tvalid,
  input  logic       data_tready,
  output logic       data_tuser,
  output logic       data_tlast,
  output logic       frame_sync,
  output logic       rx_inverted,
  output logic       overflow,
  output logic       frame_err
);

  rx_state_e   state_q, state_d;
  logic [3:0]  mode_q, mode_cur;
  logic [2:0]  bit_cnt_q, cnt_next;
  logic [7:0]  acc_q, acc_next;
  logic [7:0]  rem_q;
  logic        first_q;
  logic        two_bits, complete, out_free;
  logic [1:0]  bits_in;
  logic        corr_shift, corr_clear, corr_match, corr_inv;
  logic        sync_hit, len_zero, last_done;

  sync_correlator #(
    .SYNC_WORD (SYNC_WORD),
    .SYNC_TOL  (SYNC_TOL)
  ) u_sync_correlator (
    .clk       (clk_16M384),
    .rst       (rst_16M384),
    .clear     (corr_clear),
    .shift     (corr_shift),
    .two_bits  (two_bits),
    .bits      (RX_bits),
    .match     (corr_match),
    .inv_match (corr_inv)
  );

  always_comb begin
    state_d  = state_q;
    // Mode is live while hunting and frozen once a frame is locked.
    mode_cur = (state_q == HUNT) ? MODE_CTRL : mode_q;
    two_bits = (mode_cur == MODE_QPSK) || ((mode_cur == MODE_MIX) && (state_q == PAYLOAD));
    bits_in  = RX_bits ^ {2{rx_inverted}};
    acc_next = two_bits ? {acc_q[5:0], bits_in[1], bits_in[0]} : {acc_q[6:0], bits_in[0]};
    cnt_next = bit_cnt_q + (two_bits ? 3'd2 : 3'd1);
    complete = RX_vld && (cnt_next == 3'd0);
    out_free = !data_tvalid || data_tready;

    corr_shift = (state_q == HUNT) && RX_vld && mode_valid(MODE_CTRL);
    sync_hit   = corr_match || corr_inv;
    len_zero   = (state_q == LEN) && complete && (acc_next == 8'd0);
    last_done  = (state_q == PAYLOAD) && complete && (rem_q == 8'd1);
    corr_clear = len_zero || last_done;

    unique case (state_q)
      HUNT:    if (sync_hit) state_d = LEN;
      LEN:     if (complete) state_d = len_zero ? HUNT : PAYLOAD;
      PAYLOAD: if (last_done) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) state_q <= HUNT;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      mode_q      <= '0;
      bit_cnt_q   <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      first_q     <= 1'b0;
      data_tdata  <= '0;
      data_tvalid <= 1'b0;
      data_tuser  <= 1'b0;
      data_tlast  <= 1'b0;
      frame_sync  <= 1'b0;
      rx_inverted <= 1'b0;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (data_tvalid && data_tready) begin
        data_tvalid <= 1'b0;
        data_tuser  <= 1'b0;
        data_tlast  <= 1'b0;
      end
      unique case (state_q)
        HUNT: begin
          if (sync_hit) begin
            mode_q      <= MODE_CTRL;
            frame_sync  <= 1'b1;
            rx_inverted <= !corr_match;  // true match wins when both hit
            bit_cnt_q   <= '0;
            acc_q       <= '0;
          end
        end
        LEN: begin
          if (RX_vld) begin
            acc_q     <= acc_next;
            bit_cnt_q <= cnt_next;
            if (complete) begin
              if (len_zero) begin
                frame_err  <= 1'b1;
                frame_sync <= 1'b0;
              end else begin
                rem_q   <= acc_next;
                first_q <= 1'b1;
              end
            end
          end
        end
        PAYLOAD: begin
          if (RX_vld) begin
            acc_q     <= acc_next;
            bit_cnt_q <= cnt_next;
            if (complete) begin
              first_q <= 1'b0;
              rem_q   <= rem_q - 8'd1;
              if (last_done) frame_sync <= 1'b0;
              if (out_free) begin
                data_tvalid <= 1'b1;
                data_tdata  <= acc_next;
                data_tuser  <= first_q;
                data_tlast  <= (rem_q == 8'd1);
              end else begin
                overflow <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_deframer.sv
// Directed bench for rx_deframer: BPSK/QPSK/MIX frames, inverted sync,
// zero length, backpressure overflow and mid-frame reset.
module tb_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mode = 4'b0001;
  logic [1:0] rx_bits = '0;
  logic       rx_vld = 1'b0;
  logic       tready = 1'b1;
  logic [7:0] tdata;
  logic       tvalid, tuser, tlast, fsync, inv, ovf, ferr;

  int n_vec = 0;
  int n_err = 0;
  int err_pulses = 0;
  logic [9:0] got_q[$];

  always #5 clk = ~clk;

  rx_deframer dut (
    .clk_16M384  (clk),
    .rst_16M384  (rst),
    .MODE_CTRL   (mode),
    .RX_bits     (rx_bits),
    .RX_vld      (rx_vld),
    .data_tdata  (tdata),
    .data_tvalid (tvalid),
    .data_tready (tready),
    .data_tuser  (tuser),
    .data_tlast  (tlast),
    .frame_sync  (fsync),
    .rx_inverted (inv),
    .overflow    (ovf),
    .frame_err   (ferr)
  );

  // Collect accepted bytes as {tuser, tlast, tdata}.
  always @(negedge clk) begin
    if (tvalid && tready) got_q.push_back({tuser, tlast, tdata});
    if (ferr) err_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_sym(input logic [1:0] b);
    @(negedge clk);
    rx_bits = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] val, input int n, input int bps, input logic inv_b);
    for (int i = n - 1; i >= 0; i -= bps) begin
      if (bps == 2) send_sym({val[i], val[i-1]} ^ {inv_b, inv_b});
      else          send_sym({1'b0, val[i] ^ inv_b});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    rst = 1'b0;
    idle(1);
    check_eq("rst_tvalid", tvalid, 0);
    check_eq("rst_tdata", tdata, 0);
    check_eq("rst_tuser", tuser, 0);
    check_eq("rst_tlast", tlast, 0);
    check_eq("rst_fsync", fsync, 0);
    check_eq("rst_inv", inv, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_ferr", ferr, 0);

    // BPSK true polarity
    mode = 4'b0001;
    send_bits(16'hEB90, 16, 1, 1'b0);
    check_eq("bpsk_fsync_on", fsync, 1);
    check_eq("bpsk_inv", inv, 0);
    send_bits(16'h0002, 8, 1, 1'b0);
    send_bits(16'h00A5, 8, 1, 1'b0);
    send_bits(16'h003C, 8, 1, 1'b0);
    check_eq("bpsk_fsync_off", fsync, 0);
    idle(2);
    check_eq("bpsk_count", got_q.size(), 2);
    check_eq("bpsk_b0", got_q[0], {2'b10, 8'hA5});
    check_eq("bpsk_b1", got_q[1], {2'b01, 8'h3C});
    got_q.delete();

    // BPSK inverted polarity
    send_bits(16'hEB90, 16, 1, 1'b1);
    check_eq("inv_lock", inv, 1);
    send_bits(16'h0002, 8, 1, 1'b1);
    send_bits(16'h00A5, 8, 1, 1'b1);
    send_bits(16'h003C, 8, 1, 1'b1);
    idle(2);
    check_eq("inv_count", got_q.size(), 2);
    check_eq("inv_b0", got_q[0], {2'b10, 8'hA5});
    check_eq("inv_b1", got_q[1], {2'b01, 8'h3C});
    check_eq("inv_hold", inv, 1);
    got_q.delete();

    // QPSK single byte, output one cycle after the 4th payload symbol
    mode = 4'b0010;
    send_bits(16'hEB90, 16, 2, 1'b0);
    check_eq("qpsk_inv", inv, 0);
    send_bits(16'h0001, 8, 2, 1'b0);
    send_bits(16'h00C3, 8, 2, 1'b0);
    check_eq("qpsk_tvalid", tvalid, 1);
    check_eq("qpsk_tdata", tdata, 8'hC3);
    check_eq("qpsk_tuser", tuser, 1);
    check_eq("qpsk_tlast", tlast, 1);
    idle(2);
    check_eq("qpsk_count", got_q.size(), 1);
    got_q.delete();

    // MIX: header at 1 bit/symbol, payload at 2 bits/symbol (12 symbols)
    mode = 4'b0100;
    send_bits(16'hEB90, 16, 1, 1'b0);
    send_bits(16'h0003, 8, 1, 1'b0);
    send_bits(16'h0011, 8, 2, 1'b0);
    send_bits(16'h0022, 8, 2, 1'b0);
    send_bits(16'h000C, 6, 2, 1'b0);
    check_eq("mix_fsync_11sym", fsync, 1);
    send_bits(16'h0003, 2, 2, 1'b0);
    check_eq("mix_fsync_12sym", fsync, 0);
    idle(2);
    check_eq("mix_count", got_q.size(), 3);
    check_eq("mix_b0", got_q[0], {2'b10, 8'h11});
    check_eq("mix_b1", got_q[1], {2'b00, 8'h22});
    check_eq("mix_b2", got_q[2], {2'b01, 8'h33});
    got_q.delete();

    // Zero length rejected, then a normal frame
    mode = 4'b0001;
    err_pulses = 0;
    send_bits(16'hEB90, 16, 1, 1'b0);
    send_bits(16'h0000, 8, 1, 1'b0);
    idle(3);
    check_eq("len0_pulses", err_pulses, 1);
    check_eq("len0_fsync", fsync, 0);
    check_eq("len0_no_tvalid", got_q.size(), 0);
    send_bits(16'hEB90, 16, 1, 1'b0);
    send_bits(16'h0001, 8, 1, 1'b0);
    send_bits(16'h005A, 8, 1, 1'b0);
    idle(2);
    check_eq("after_len0_count", got_q.size(), 1);
    check_eq("after_len0_b0", got_q[0], {2'b11, 8'h5A});
    got_q.delete();

    // Backpressure: first byte held, second dropped, then reset mid-frame
    tready = 1'b0;
    send_bits(16'hEB90, 16, 1, 1'b0);
    send_bits(16'h0003, 8, 1, 1'b0);
    send_bits(16'h0011, 8, 1, 1'b0);
    check_eq("bp_ovf_first", ovf, 0);
    send_bits(16'h0022, 8, 1, 1'b0);
    check_eq("bp_ovf_second", ovf, 1);
    check_eq("bp_held_tdata", tdata, 8'h11);
    check_eq("bp_held_tvalid", tvalid, 1);
    send_bits(16'h0003, 4, 1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrst_tvalid", tvalid, 0);
    check_eq("mrst_tdata", tdata, 0);
    check_eq("mrst_ovf", ovf, 0);
    check_eq("mrst_fsync", fsync, 0);
    check_eq("mrst_tuser", tuser, 0);
    rst = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
